crypto1_subkey_extend: RTL

CRYPTO1_SUBKEY_EXTEND -- requirements
Module: crypto1_subkey_extend

---
 rtl/crypto1_subkey_extend.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/crypto1_subkey_extend.sv
// Crypto1 20-bit subkey extension: grows a seed by NEXT keystream bits through two ping-pong candidate buffers.
// Optional statistics counters are enabled with `define CRYPTO1_SUBKEY_STATS_EN.
module crypto1_subkey_extend #(
  parameter int NEXT  = 4,
  parameter int DEPTH = 16
) (
  input  logic                         CLK,
  input  logic                         RESETn,
  input  logic [NEXT:0]                BITSTREAM,
  input  logic                         SEED_VALID,
  input  logic [19:0]                  SEED,
  output logic                         SEED_READY,
  output logic                         OUT_VALID,
  output logic [19+NEXT:0]             OUT_KEY,
  output logic                         OUT_LAST,
  input  logic                         OUT_READY,
  output logic                         DONE,
  output logic [$clog2(DEPTH+1)-1:0]   DONE_CNT,
  output logic                         OVF,
  output logic [31:0]                  STAT_SEEDS,
  output logic [31:0]                  STAT_KEYS
);
  localparam int KW = 20 + NEXT;
  localparam int BW = NEXT + 1;
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {IDLE, EXTEND, SWAP, DRAIN, FINISH} state_t;
  state_t state, state_nxt;

  logic [KW-1:0] buf_a [DEPTH];
  logic [KW-1:0] buf_b [DEPTH];
  logic          sel;
  logic [CW-1:0] src_cnt, dst_cnt;
  logic [IW-1:0] idx, idx_inc;
  logic          b;
  logic [3:0]    k;
  logic [NEXT:0] bits_q;

  logic [KW-1:0] src_key, src_next_key, dst_head, new_key;
  logic [19:0]   nlf_in;
  logic          accept, last_pair, seed_fire, xfer;

  function automatic logic fa(input logic p, q, r, s);
    return (q & ~r & ~s) | (p & ~q & r) | (p & ~q & s) | (r & s);
  endfunction

  function automatic logic fb(input logic p, q, r, s);
    return (q & r & s) | (~q & r & ~s) | (~p & q & ~s) | (~p & ~q & s);
  endfunction

  function automatic logic fc(input logic p, q, r, s, t);
    return (~q & ~r & ~s & t) | (p & q & s) | (~p & ~r & s & t) |
           (p & ~q & ~t) | (q & r & t) | (q & r & s);
  endfunction

  function automatic logic nlf(input logic [19:0] x);
    return fc(fa(x[19], x[18], x[17], x[16]), fb(x[15], x[14], x[13], x[12]),
              fa(x[11], x[10], x[9], x[8]), fa(x[7], x[6], x[5], x[4]),
              fb(x[3], x[2], x[1], x[0]));
  endfunction

  assign seed_fire  = SEED_VALID && SEED_READY;
  assign xfer       = OUT_VALID && OUT_READY;
  assign SEED_READY = (state == IDLE);
  assign DONE       = (state == FINISH);

  // sel=0: A is the source of the current level, B collects survivors
  always_comb begin
    idx_inc      = idx + IW'(1);
    src_key      = sel ? buf_b[idx] : buf_a[idx];
    src_next_key = sel ? buf_b[idx_inc] : buf_a[idx_inc];
    dst_head     = sel ? buf_a[0] : buf_b[0];
    nlf_in       = {b, 19'(src_key >> k)};
    accept       = (nlf(nlf_in) == |(bits_q & (BW'(1) << k)));
    new_key      = src_key | (KW'(b) << (5'd19 + 5'(k)));
    last_pair    = b && ((CW'(idx) + CW'(1)) == src_cnt);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (SEED_VALID) state_nxt = EXTEND;
      EXTEND:  if (last_pair) state_nxt = SWAP;
      SWAP: begin
        if (dst_cnt == '0)          state_nxt = FINISH;
        else if (k == 4'(NEXT))     state_nxt = DRAIN;
        else                        state_nxt = EXTEND;
      end
      DRAIN:   if (xfer && OUT_LAST) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state     <= IDLE;
      sel       <= 1'b0;
      src_cnt   <= '0;
      dst_cnt   <= '0;
      idx       <= '0;
      b         <= 1'b0;
      k         <= '0;
      bits_q    <= '0;
      OUT_VALID <= 1'b0;
      OUT_KEY   <= '0;
      OUT_LAST  <= 1'b0;
      DONE_CNT  <= '0;
      OVF       <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (seed_fire) begin
          bits_q  <= BITSTREAM;
          sel     <= 1'b0;
          src_cnt <= CW'(1);
          dst_cnt <= '0;
          idx     <= '0;
          b       <= 1'b0;
          k       <= 4'd1;
          OVF     <= 1'b0;
        end
        EXTEND: begin
          if (accept) begin
            if (dst_cnt == CW'(DEPTH)) OVF <= 1'b1;
            else                       dst_cnt <= dst_cnt + CW'(1);
          end
          b <= ~b;
          if (last_pair) idx <= '0;
          else if (b)    idx <= idx_inc;
        end
        SWAP: begin
          sel     <= ~sel;
          src_cnt <= dst_cnt;
          dst_cnt <= '0;
          idx     <= '0;
          b       <= 1'b0;
          k       <= k + 4'd1;
          if (dst_cnt == '0) begin
            DONE_CNT <= '0;
          end else if (k == 4'(NEXT)) begin
            // first candidate is read from the pre-swap destination buffer
            OUT_VALID <= 1'b1;
            OUT_KEY   <= dst_head;
            OUT_LAST  <= (dst_cnt == CW'(1));
          end
        end
        DRAIN: if (xfer) begin
          if (OUT_LAST) begin
            OUT_VALID <= 1'b0;
            OUT_LAST  <= 1'b0;
            DONE_CNT  <= src_cnt;
          end else begin
            idx      <= idx_inc;
            OUT_KEY  <= src_next_key;
            OUT_LAST <= ((CW'(idx) + CW'(2)) == src_cnt);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (state == IDLE && SEED_VALID) begin
      buf_a[0] <= KW'(SEED);
    end else if (state == EXTEND && accept && dst_cnt != CW'(DEPTH)) begin
      if (sel) buf_a[dst_cnt[IW-1:0]] <= new_key;
      else     buf_b[dst_cnt[IW-1:0]] <= new_key;
    end
  end

`ifdef CRYPTO1_SUBKEY_STATS_EN
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      STAT_SEEDS <= '0;
      STAT_KEYS  <= '0;
    end else begin
      if (seed_fire) STAT_SEEDS <= STAT_SEEDS + 32'd1;
      if (xfer)      STAT_KEYS  <= STAT_KEYS + 32'd1;
    end
  end
`else
  assign STAT_SEEDS = '0;
  assign STAT_KEYS  = '0;
`endif

endmodule
